ahfp_add_arbiter: RTL and testbench
===================================

Name: ahfp_add_arbiter

Overview:
- Shares a single combinational ahfp_add single-precision adder between NUM_REQ independent requesters.
- Each requester uses a valid/ready handshake; arbitration is round-robin.
- The sum is captured in one output register, tagged with the requester index, and handed downstream on a valid/ready response channel.
- Sits between the operand-producing engines and the single adder instance. Its purpose is to avoid replicating adders.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of requester tag; must be ≥ ceil(log2(NUM_REQ)).
- FP_W, 32, floating-point word width (IEEE-754 single).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_dataa  in  NUM_REQ*FP_W  packed operand A; requester i occupies bits [i*FP_W +: FP_W].
- req_datab  in  NUM_REQ*FP_W  packed operand B; same packing.
- resp_valid  out  1  output register holds a result.
- resp_ready  in  1  downstream accepts the result.
- resp_id  out  ID_W  index of the requester that produced the result.
- resp_result  out  FP_W  registered ahfp_add sum.
- busy  out  1  high whenever resp_valid is high, or any req_valid is high.

Behaviour:
- Reset: clk and reset are the only clock/reset; reset is asynchronous and active-high.
  - resp_valid=0, resp_id=0, resp_result=0.
  - Round-robin pointer=0.
  - req_ready=0 while reset is asserted.
  - Reset mid-transaction discards the held result; no response is emitted for it.
- Slot free: slot_free = !resp_valid || resp_ready.
- Grant (combinational):
  - When slot_free=1, grant the first requester with req_valid=1, searching from pointer upward modulo NUM_REQ.
  - req_ready[g]=1 for the granted index only.
  - When slot_free=0, req_ready is all zero.
  - Asserting req_ready never depends on the same requester's req_valid being low; no combinational loop exists from req_valid to resp_*.
- Accept: on a clock edge where req_valid[g] && req_ready[g]:
  - resp_result <= ahfp_add(req_dataa[g], req_datab[g]).
  - resp_id <= g; resp_valid <= 1.
  - pointer <= (g+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
- Drain: resp_valid && resp_ready with no new accept → resp_valid <= 0.
  - Drain and accept in the same cycle → the new result overwrites, and resp_valid stays 1. This gives full throughput: one operation per cycle.
- Latency: the result appears one cycle after acceptance.
- Stall: while resp_valid=1 and resp_ready=0:
  - resp_result and resp_id are held stable.
  - The pointer does not move.
- No requests: the pointer does not move.
- Fairness: a continuously requesting requester waits at most NUM_REQ-1 grants.
- Operand muxing: pure selection; the adder sees the operands of the granted index only. When no grant is issued, the adder is fed requester 0 (result unused).
- No special handling of NaN/Inf is added; the output is exactly the ahfp_add output.

Optional Feature:
- Macro: AHFP_ADD_ARBITER_PERF_EN.
- When defined:
  - Adds output perf_ops (32 bits): counts accepted requests, wraps at 2^32.
  - Adds output perf_stall (32 bits): counts cycles where any req_valid=1 and slot_free=0.
  - Both counters reset to 0 on reset.
- When undefined: neither port nor counter logic exists; behaviour is otherwise identical.

Decomposition:
- Shared package/include ahfp_pkg:
  - FP_W=32.
  - IEEE field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22.
  - FP_ZERO=32'h00000000.
  - Function clog2 for sizing ID_W.
- One natural sub-module: rr_arbiter.
  - Parameter NUM_REQ; inputs req, pointer, enable.
  - Outputs one-hot grant and binary grant index.
  - Reused elsewhere for other shared FP units.
- ahfp_add is instantiated once, unmodified.

Test Plan:
- Single request: req0 A=3F800000, B=40000000, resp_ready=1 → next cycle resp_valid=1, resp_id=0, resp_result=40400000.
- Round-robin, all 4 requesters valid together with A=40000000, B=40800000 each, resp_ready=1:
  - Grants go 0,1,2,3,0 on consecutive cycles.
  - Each resp_result=40C00000; resp_id sequence is 0,1,2,3.
- Backpressure:
  - req1 A=40400000, B=40600000 accepted → resp_result=40D00000.
  - Hold resp_ready=0 for 3 cycles with req2 valid → req_ready=0000 and outputs stable.
  - Raise resp_ready → req2 is granted in that same cycle.
- Wrap and skip:
  - Pointer=3 (after a grant to 2); only req1 valid with A=43FA0000, B=41133333.
  - → grant 1, resp_result=43FE999A, pointer becomes 2.
- Reset mid-stall: resp_valid=1, resp_ready=0, then assert reset asynchronously between clock edges → resp_valid=0 immediately, pointer=0, and no stale response after release.
- AHFP_ADD_ARBITER_PERF_EN defined: 10 accepts plus 3 stall cycles → perf_ops=10, perf_stall=3; both counters are 0 after reset.

Source files
------------

// File: rtl/ahfp_pkg.sv
// Shared single-precision constants and sizing helpers for the ahfp arithmetic blocks.
package ahfp_pkg;

    localparam int FP_W     = 32;
    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;
    localparam int MAN_MSB  = 22;

    localparam logic [FP_W-1:0] FP_ZERO = 32'h0000_0000;
    localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC0_0000;

    typedef logic [FP_W-1:0] fp_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/ahfp_add.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even.
module ahfp_add
    import ahfp_pkg::*;
(
    input  logic [FP_W-1:0] dataa,
    input  logic [FP_W-1:0] datab,
    output logic [FP_W-1:0] result
);

    fp_t         x, y;
    logic        sx, sy, sub;
    logic [7:0]  ex, ey, ex_eff, ey_eff, diff;
    logic [23:0] mx, my;
    logic [49:0] ax, ay, norm;
    logic [50:0] sum;
    logic [5:0]  lz, shift;
    logic [8:0]  e_norm, e_fin;
    logic [24:0] sig_r;
    logic [23:0] sig_f;
    logic        guard, sticky, rnd;

    always_comb begin
        // x always carries the larger magnitude, so subtraction never goes negative
        if (dataa[EXP_MSB:0] >= datab[EXP_MSB:0]) begin
            x = dataa;
            y = datab;
        end else begin
            x = datab;
            y = dataa;
        end
        sx     = x[SIGN_BIT];
        sy     = y[SIGN_BIT];
        sub    = sx ^ sy;
        ex     = x[EXP_MSB:EXP_LSB];
        ey     = y[EXP_MSB:EXP_LSB];
        mx     = {|ex, x[MAN_MSB:0]};
        my     = {|ey, y[MAN_MSB:0]};
        ex_eff = (ex == 8'd0) ? 8'd1 : ex;
        ey_eff = (ey == 8'd0) ? 8'd1 : ey;
        diff   = ex_eff - ey_eff;
        ax     = {mx, 26'd0};
        ay     = (diff > 8'd26) ? {49'd0, |my} : ({my, 26'd0} >> diff);
        sum    = sub ? ({1'b0, ax} - {1'b0, ay}) : ({1'b0, ax} + {1'b0, ay});

        lz = 6'd50;
        for (int i = 0; i < 50; i++) begin
            if (sum[i]) begin
                lz = 6'(49 - i);
            end
        end
        // Never shift below the minimum exponent; the result then stays subnormal
        shift = ({2'b0, lz} < ex_eff) ? lz : 6'(ex_eff - 8'd1);

        if (sum[50]) begin
            norm   = {sum[50:2], sum[1] | sum[0]};
            e_norm = {1'b0, ex_eff} + 9'd1;
        end else begin
            norm   = sum[49:0] << shift;
            e_norm = {1'b0, ex_eff} - {3'd0, shift};
        end

        guard  = norm[25];
        sticky = |norm[24:0];
        rnd    = guard & (sticky | norm[26]);
        sig_r  = {1'b0, norm[49:26]} + 25'(rnd);
        if (sig_r[24]) begin
            sig_f = sig_r[24:1];
            e_fin = e_norm + 9'd1;
        end else begin
            sig_f = sig_r[23:0];
            e_fin = e_norm;
        end

        if (ex == 8'hFF) begin
            if ((x[MAN_MSB:0] != 23'd0) || ((ey == 8'hFF) && sub)) begin
                result = FP_QNAN;
            end else begin
                result = x;
            end
        end else if (sum == 51'd0) begin
            result = {sx & sy, 31'd0};
        end else if (e_fin >= 9'd255) begin
            result = {sx, 8'hFF, 23'd0};
        end else begin
            result = {sx, (sig_f[23] ? e_fin[7:0] : 8'd0), sig_f[22:0]};
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first active request at or above pointer, modulo NUM_REQ.
module rr_arbiter
    import ahfp_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(pointer) + k) % NUM_REQ;
            if (enable && !found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/ahfp_add_arbiter.sv
// Round-robin sharing of one ahfp_add among NUM_REQ requesters with a registered, tagged result.
// Define AHFP_ADD_ARBITER_PERF_EN to add the perf_ops / perf_stall counters.
module ahfp_add_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int FP_W    = 32
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_dataa,
    input  logic [NUM_REQ*FP_W-1:0] req_datab,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [ID_W-1:0]         resp_id,
    output logic [FP_W-1:0]         resp_result,
`ifdef AHFP_ADD_ARBITER_PERF_EN
    output logic [31:0]             perf_ops,
    output logic [31:0]             perf_stall,
`endif
    output logic                    busy
);

    logic              slot_free;
    logic              accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W-1:0]   pointer;
    logic [ID_W-1:0]   pointer_next;
    logic [FP_W-1:0]   sel_a, sel_b, sum;

    assign slot_free = !resp_valid || resp_ready;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (ID_W)
    ) u_arb (
        .req       (req_valid),
        .pointer   (pointer),
        .enable    (slot_free && !reset),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |grant;

    // grant_idx is 0 with no grant, so the adder idles on requester 0
    assign sel_a = req_dataa[grant_idx*FP_W +: FP_W];
    assign sel_b = req_datab[grant_idx*FP_W +: FP_W];

    ahfp_add u_add (
        .dataa  (sel_a),
        .datab  (sel_b),
        .result (sum)
    );

    assign pointer_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_valid  <= 1'b0;
            resp_id     <= '0;
            resp_result <= '0;
            pointer     <= '0;
        end else if (accept) begin
            resp_valid  <= 1'b1;
            resp_id     <= grant_idx;
            resp_result <= sum;
            pointer     <= pointer_next;
        end else if (resp_ready) begin
            resp_valid  <= 1'b0;
        end
    end

    assign busy = resp_valid || (|req_valid);

`ifdef AHFP_ADD_ARBITER_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (accept) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if ((|req_valid) && !slot_free) begin
                perf_stall <= perf_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ahfp_add_arbiter.sv
// Scoreboard bench for ahfp_add_arbiter: directed vectors with hand-computed sums.
module tb_ahfp_add_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;
    localparam int FP_W    = 32;

    typedef struct packed {
        logic [ID_W-1:0] id;
        logic [FP_W-1:0] res;
    } resp_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [NUM_REQ*FP_W-1:0] req_dataa;
    logic [NUM_REQ*FP_W-1:0] req_datab;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [ID_W-1:0]         resp_id;
    logic [FP_W-1:0]         resp_result;
    logic                    busy;
`ifdef AHFP_ADD_ARBITER_PERF_EN
    logic [31:0]             perf_ops;
    logic [31:0]             perf_stall;
`endif

    logic [FP_W-1:0] op_a    [NUM_REQ];
    logic [FP_W-1:0] op_b    [NUM_REQ];
    logic [FP_W-1:0] exp_sum [NUM_REQ];

    resp_t sb_q[$];
    int    n_vec = 0;
    int    n_bad = 0;
    int    mdl_ptr = 0;
    logic  mdl_valid = 1'b0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_pack
        assign req_dataa[i*FP_W +: FP_W] = op_a[i];
        assign req_datab[i*FP_W +: FP_W] = op_b[i];
    end

    ahfp_add_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .FP_W    (FP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_dataa   (req_dataa),
        .req_datab   (req_datab),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_result (resp_result),
`ifdef AHFP_ADD_ARBITER_PERF_EN
        .perf_ops    (perf_ops),
        .perf_stall  (perf_stall),
`endif
        .busy        (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %08h, expected %08h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] e);
        op_a[i]    = a;
        op_b[i]    = b;
        exp_sum[i] = e;
    endtask

    // Reference model of grant/slot state plus scoreboard monitor, sampled mid-cycle.
    always @(negedge clk) begin
        int                 g;
        int                 idx;
        logic               slot;
        logic [NUM_REQ-1:0] exp_rdy;
        resp_t              e;
        if (reset) begin
            chk("ready_in_reset", 32'(req_ready), 32'd0);
            chk("valid_in_reset", 32'(resp_valid), 32'd0);
            sb_q.delete();
            mdl_valid = 1'b0;
            mdl_ptr   = 0;
        end else begin
            slot = !mdl_valid || resp_ready;
            g    = -1;
            if (slot) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (mdl_ptr + k) % NUM_REQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            end
            exp_rdy = (g >= 0) ? (NUM_REQ'(1) << g) : '0;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("resp_valid", 32'(resp_valid), 32'(mdl_valid));
            chk("busy", 32'(busy), 32'(mdl_valid || (|req_valid)));
            if (resp_valid && resp_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_resp", 32'(resp_id), 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    chk("resp_id", 32'(resp_id), 32'(e.id));
                    chk("resp_result", resp_result, e.res);
                end
            end
            if (g >= 0) begin
                sb_q.push_back({ID_W'(g), exp_sum[g]});
                mdl_ptr   = (g + 1) % NUM_REQ;
                mdl_valid = 1'b1;
            end else if (resp_ready) begin
                mdl_valid = 1'b0;
            end
        end
    end

    logic [NUM_REQ-1:0] rr_seq [5];

    initial begin
        rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100;
        rr_seq[3] = 4'b1000; rr_seq[4] = 4'b0001;
        reset      = 1'b1;
        req_valid  = '0;
        resp_ready = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h0, 32'h0, 32'h0);

        // Reset state, with a request pending to prove ready stays low
        step();
        req_valid = 4'b0001;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_resp_result", resp_result, 32'h0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        step();
        reset = 1'b0;

        // Single request: 1.0 + 2.0
        set_req(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk("single_valid", 32'(resp_valid), 32'd1);
        chk("single_id", 32'(resp_id), 32'd0);
        chk("single_result", resp_result, 32'h4040_0000);
        step();

        // Reset pulse so the round-robin sequence starts from pointer 0
        reset = 1'b1;
        step();
        reset = 1'b0;

        // All four requesting: 2.0 + 4.0
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h4000_0000, 32'h4080_0000, 32'h40C0_0000);
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_grant", 32'(req_ready), 32'(rr_seq[k]));
            step();
        end
        req_valid = '0;
        step();

        // Backpressure: req1 3.0 + 3.5, then stall with req2 waiting
        set_req(1, 32'h4040_0000, 32'h4060_0000, 32'h40D0_0000);
        req_valid = 4'b0010;
        #1;
        chk("bp_grant1", 32'(req_ready), 32'b0010);
        step();
        set_req(2, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000);
        req_valid  = 4'b0100;
        resp_ready = 1'b0;
        repeat (3) begin
            #1;
            chk("stall_ready", 32'(req_ready), 32'd0);
            chk("stall_result", resp_result, 32'h40D0_0000);
            chk("stall_id", 32'(resp_id), 32'd1);
            step();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_grant2", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        step();

        // Wrap and skip: pointer 3, only req1 valid; 500.0 + 9.2
        set_req(1, 32'h43FA_0000, 32'h4113_3333, 32'h43FE_999A);
        req_valid = 4'b0010;
        #1;
        chk("wrap_grant", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        chk("wrap_result", resp_result, 32'h43FE_999A);
        chk("wrap_id", 32'(resp_id), 32'd1);
        step();
        req_valid = 4'b0110;
        #1;
        chk("ptr2_grant", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        step();

        // Mixed signs: 3.0 + -2.0 then 1.0 + -3.0
        set_req(3, 32'h4040_0000, 32'hC000_0000, 32'h3F80_0000);
        req_valid = 4'b1000;
        step();
        req_valid = '0;
        chk("sub_result", resp_result, 32'h3F80_0000);
        set_req(0, 32'h3F80_0000, 32'hC040_0000, 32'hC000_0000);
        req_valid = 4'b0001;
        step();
        req_valid = '0;
        chk("neg_result", resp_result, 32'hC000_0000);
        step();

        // Reset during a stall discards the held result
        set_req(1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        resp_ready = 1'b0;
        req_valid  = 4'b0010;
        step();
        req_valid = '0;
        step();
        #2;
        req_valid = 4'b1111;
        reset     = 1'b1;
        #1;
        chk("async_rst_valid", 32'(resp_valid), 32'd0);
        chk("async_rst_ready", 32'(req_ready), 32'd0);
        step();
        reset      = 1'b0;
        req_valid  = '0;
        resp_ready = 1'b1;
        repeat (3) begin
            #1;
            chk("no_stale", 32'(resp_valid), 32'd0);
            step();
        end
        set_req(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000);
        set_req(3, 32'h4080_0000, 32'h4080_0000, 32'h4100_0000);
        req_valid = 4'b1001;
        #1;
        chk("ptr_after_rst", 32'(req_ready), 32'b0001);
        step();
        #1;
        chk("ptr_after_rst2", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;
        step();

`ifdef AHFP_ADD_ARBITER_PERF_EN
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("perf_ops_rst", perf_ops, 32'd0);
        chk("perf_stall_rst", perf_stall, 32'd0);
        set_req(0, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000);
        req_valid = 4'b0001;
        repeat (10) step();
        resp_ready = 1'b0;
        repeat (3) step();
        req_valid = '0;
        chk("perf_ops", perf_ops, 32'd10);
        chk("perf_stall", perf_stall, 32'd3);
        resp_ready = 1'b1;
        step();
        step();
`endif

        step();
        step();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
